elevator_scan_controller: RTL and testbench
===========================================

Name: elevator_scan_controller

Overview:
Parametrised car controller for one elevator shaft serving N_FLOORS landings, with a SCAN (collective) dispatch policy. It latches hall up/down calls and in-car requests and decides motor enable and direction. It also sequences a timed door-open dwell and drives the request indicator lamps. It sits between the button/sensor front end and the motor/door drivers, replacing the fixed 5-floor queue-based controller.

Parameters:
N_FLOORS, 8, number of landings (>=2); floor 0 is the bottom landing
FLOOR_W, $clog2(N_FLOORS), width of the floor index
DOOR_CYCLES, 4, clock cycles the door stays open per stop (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset: one clock domain; asynchronous, active-low
call_up  input  N_FLOORS  hall up-call pulses; bit N_FLOORS-1 ignored
call_dn  input  N_FLOORS  hall down-call pulses; bit 0 ignored
car_req  input  N_FLOORS  in-car floor request pulses
floor_cur  input  FLOOR_W  current floor index from the position sensor
at_floor  input  1  car is level with floor_cur (stop permitted)
motor  output  1  1 = move, 0 = stop
direction  output  1  1 = up, 0 = down; meaningful while motor=1, held otherwise
door_open  output  1  door command
pend_up, pend_dn, pend_car  output  N_FLOORS each  latched request lamps
fault  output  1  sticky: floor_cur >= N_FLOORS was seen

Behaviour:
- All state updates on rising clk. rst=0 asynchronously sets: state IDLE, motor=0, direction=1, door_open=0, all pend_*=0, door counter=0, fault=0.
- Request bank:
  - pend_x[f] <= pend_x[f] | x[f] every cycle.
  - A clear (below) wins over a new press for the same bit in the same cycle, except in DOOR, where the press reloads the dwell instead.
  - The ignored bits are never set.
- Helper terms: above = any pending bit at floors > floor_cur; below = any pending bit at floors < floor_cur; here = any pending bit at floor_cur.
- FSM states: IDLE, MOVING, DOOR.
  - IDLE:
    - if here & at_floor -> DOOR.
    - else if above|below: set direction (keep current direction if requests exist that way, else reverse); motor=1 -> MOVING. Decision takes 1 cycle after the request is latched (2 cycles from press).
    - else stay.
  - MOVING, checked only when at_floor=1. Stop at f=floor_cur if car_req[f], or a hall call matching direction, or an opposite-direction hall call with no further requests in the current direction.
    - Stop: motor=0 -> DOOR.
    - Forced stop at floor 0 moving down or at floor N_FLOORS-1 moving up.
    - If no requests remain anywhere: motor=0 -> IDLE.
  - DOOR:
    - Entry cycle: door_open=1, counter=DOOR_CYCLES-1; clear pend_car[f] and the hall call matching the departure direction. At a terminal floor or in IDLE-entry, clear both hall calls.
    - While open: decrement each cycle; a new press at floor_cur in service direction reloads the counter.
    - At 0: door_open=0 -> IDLE (re-evaluates next cycle).
- Door must be 0 whenever motor=1 (invariant). motor never 1 while state is DOOR.
- floor_cur >= N_FLOORS: motor=0, door_open=0, fault=1, state IDLE, held until reset; requests still latch.
- Reset mid-motion or mid-dwell: immediate outputs-to-reset; all pending requests are lost.

Decomposition:
- Package elev_pkg: state enum (IDLE, MOVING, DOOR), DIR_UP=1'b1 / DIR_DN=1'b0 constants, floor index typedef helper.
- Sub-module elev_req_bank: the three pending vectors, set/clear logic, and above/below/here reductions. Parametrised by N_FLOORS.

Test Plan:
1. Reset, floor_cur=0, at_floor=1, car_req[5] pulse -> motor=1, direction=1 two cycles later. At floor_cur=5: motor=0, door_open=1 for 4 cycles, pend_car[5]=0, then IDLE.
2. Car moving up from floor 1 toward 6; call_up[3] pressed and call_dn[4] pressed -> stops at 3 (clears pend_up[3]), passes 4, stops at 6. Then reverses to 4 with direction=0 and clears pend_dn[4].
3. Idle at floor 2, call_up[2] pulse -> door_open=1 within 2 cycles, motor stays 0. A second call_up[2] during dwell reloads the counter (door open 4 cycles after last press).
4. N_FLOORS=4: call_up[3] and call_dn[0] pressed -> pend_up[3], pend_dn[0] remain 0, motor stays 0.
5. Moving down at floor 3, rst asserted low for 1 cycle -> motor=0, door_open=0, all pend_*=0 immediately, asynchronously.
6. N_FLOORS=6, floor_cur driven to 7 -> fault=1, motor=0. fault persists after floor_cur returns to 2, until reset.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator SCAN car controller.
package elev_pkg;

    // state  | meaning
    // IDLE   | car parked, door closed; picks a direction or opens for a call here
    // MOVING | motor on; evaluates stop/continue each time the car levels at a floor
    // DOOR   | car stopped, door open; dwell timer running
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } elev_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Common width for floor comparisons, wide enough for any floor_cur
    // (including out-of-range sensor values) and any loop index.
    typedef logic [7:0] floor_idx_t;

    function automatic floor_idx_t to_floor_idx(input int f);
        return floor_idx_t'(f);
    endfunction

endpackage

// File: rtl/elev_req_bank.sv
// Pending request bank: hall up/down and in-car lamps, clear-at-floor logic,
// and the above/below/here reductions the dispatcher works from.
module elev_req_bank
    import elev_pkg::*;
#(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_up,
    input  logic [N_FLOORS-1:0] call_dn,
    input  logic [N_FLOORS-1:0] car_req,
    input  logic [FLOOR_W-1:0]  floor_cur,
    input  logic                clr_car,
    input  logic                clr_up,
    input  logic                clr_dn,
    output logic [N_FLOORS-1:0] pend_up,
    output logic [N_FLOORS-1:0] pend_dn,
    output logic [N_FLOORS-1:0] pend_car,
    output logic                above,
    output logic                below,
    output logic                here,
    output logic                here_car,
    output logic                here_up,
    output logic                here_dn,
    output logic                press_car,
    output logic                press_up,
    output logic                press_dn
);

    // No up call from the top landing, no down call from the bottom one.
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    logic [N_FLOORS-1:0] sel;
    logic [N_FLOORS-1:0] gt;
    logic [N_FLOORS-1:0] lt;
    logic [N_FLOORS-1:0] any_pend;
    floor_idx_t          cur;

    // Floor position masks relative to the car; an out-of-range floor selects nothing.
    always_comb begin
        sel = '0;
        gt  = '0;
        lt  = '0;
        cur = floor_idx_t'(floor_cur);
        for (int f = 0; f < N_FLOORS; f++) begin
            sel[f] = (to_floor_idx(f) == cur);
            gt[f]  = (to_floor_idx(f) >  cur);
            lt[f]  = (to_floor_idx(f) <  cur);
        end
    end

    // Reductions over all pending lamps plus raw presses at the current floor.
    always_comb begin
        any_pend  = pend_up | pend_dn | pend_car;
        above     = |(any_pend & gt);
        below     = |(any_pend & lt);
        here      = |(any_pend & sel);
        here_car  = |(pend_car & sel);
        here_up   = |(pend_up & sel);
        here_dn   = |(pend_dn & sel);
        press_car = |(car_req & sel);
        press_up  = |(call_up & UP_MASK & sel);
        press_dn  = |(call_dn & DN_MASK & sel);
    end

    // Latch presses; a clear at the current floor beats a same-cycle press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_up  <= '0;
            pend_dn  <= '0;
            pend_car <= '0;
        end else begin
            pend_car <= (pend_car | car_req) & ~(sel & {N_FLOORS{clr_car}});
            pend_up  <= (pend_up | call_up) & UP_MASK & ~(sel & {N_FLOORS{clr_up}});
            pend_dn  <= (pend_dn | call_dn) & DN_MASK & ~(sel & {N_FLOORS{clr_dn}});
        end
    end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN (collective) car controller for one shaft: dispatch, door dwell and
// fault latch around the pending-request bank.
//
// state  | meaning
// IDLE   | parked, door closed; opens for a call here or picks a direction
// MOVING | motor on; at each level floor decides stop / continue / park
// DOOR   | door open; down-counter dwell, reloaded by presses served here
module elevator_scan_controller
    import elev_pkg::*;
#(
    parameter int N_FLOORS    = 8,
    parameter int FLOOR_W     = $clog2(N_FLOORS),
    parameter int DOOR_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_up,
    input  logic [N_FLOORS-1:0] call_dn,
    input  logic [N_FLOORS-1:0] car_req,
    input  logic [FLOOR_W-1:0]  floor_cur,
    input  logic                at_floor,
    output logic                motor,
    output logic                direction,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pend_up,
    output logic [N_FLOORS-1:0] pend_dn,
    output logic [N_FLOORS-1:0] pend_car,
    output logic                fault
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    elev_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             svc_up;
    logic             svc_dn;

    logic above, below, here, here_car, here_up, here_dn;
    logic press_car, press_up, press_dn;
    logic clr_car, clr_up, clr_dn;

    logic floor_ok, at_bot, at_top, ahead, stop_hit, enter_door;
    logic keep_dir, clear_both, entry_up, entry_dn, in_door, reload;

    elev_req_bank #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .call_up   (call_up),
        .call_dn   (call_dn),
        .car_req   (car_req),
        .floor_cur (floor_cur),
        .clr_car   (clr_car),
        .clr_up    (clr_up),
        .clr_dn    (clr_dn),
        .pend_up   (pend_up),
        .pend_dn   (pend_dn),
        .pend_car  (pend_car),
        .above     (above),
        .below     (below),
        .here      (here),
        .here_car  (here_car),
        .here_up   (here_up),
        .here_dn   (here_dn),
        .press_car (press_car),
        .press_up  (press_up),
        .press_dn  (press_dn)
    );

    // Stop decision, which hall calls a stop serves, and request-bank clears.
    always_comb begin
        floor_ok = floor_idx_t'(floor_cur) < to_floor_idx(N_FLOORS);
        at_bot   = (floor_cur == '0);
        at_top   = (floor_idx_t'(floor_cur) == to_floor_idx(N_FLOORS - 1));
        ahead    = (direction == DIR_UP) ? above : below;
        // Opposite-direction hall call only stops the car when nothing lies further on.
        stop_hit = here_car
                 | ((direction == DIR_UP) ? here_up : here_dn)
                 | (((direction == DIR_UP) ? here_dn : here_up) & ~ahead);
        enter_door = ~fault & floor_ok & at_floor &
                     (((state == IDLE) & here) | ((state == MOVING) & stop_hit));
        // Departure keeps the current direction if a matching call is here or work lies ahead.
        keep_dir   = ((direction == DIR_UP) ? here_up : here_dn) | ahead;
        clear_both = (state == IDLE) | at_bot | at_top;
        entry_up   = clear_both | (keep_dir ? (direction == DIR_UP) : (direction == DIR_DN));
        entry_dn   = clear_both | (keep_dir ? (direction == DIR_DN) : (direction == DIR_UP));
        in_door    = (state == DOOR) & floor_ok & ~fault;
        clr_car    = enter_door | in_door;
        clr_up     = enter_door ? entry_up : (in_door & svc_up);
        clr_dn     = enter_door ? entry_dn : (in_door & svc_dn);
        reload     = in_door & (press_car | (svc_up & press_up) | (svc_dn & press_dn));
    end

    // Main FSM with registered motor/direction/door outputs and sticky fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            motor     <= 1'b0;
            direction <= DIR_UP;
            door_open <= 1'b0;
            cnt       <= '0;
            svc_up    <= 1'b0;
            svc_dn    <= 1'b0;
            fault     <= 1'b0;
        end else if (fault || !floor_ok) begin
            fault     <= 1'b1;
            state     <= IDLE;
            motor     <= 1'b0;
            door_open <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enter_door) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        cnt       <= CNT_LOAD;
                        svc_up    <= entry_up;
                        svc_dn    <= entry_dn;
                    end else if (above || below) begin
                        if ((direction == DIR_UP && above) || (direction == DIR_DN && !below))
                            direction <= DIR_UP;
                        else
                            direction <= DIR_DN;
                        motor <= 1'b1;
                        state <= MOVING;
                    end
                end
                MOVING: begin
                    if (at_floor) begin
                        if (enter_door) begin
                            motor     <= 1'b0;
                            state     <= DOOR;
                            door_open <= 1'b1;
                            cnt       <= CNT_LOAD;
                            svc_up    <= entry_up;
                            svc_dn    <= entry_dn;
                        end else if (!ahead) begin
                            // Terminal floor or nothing further this way: park and re-decide.
                            motor <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DOOR: begin
                    if (reload) begin
                        cnt <= CNT_LOAD;
                    end else if (cnt == '0) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    motor     <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for the SCAN car controller: 8-floor main car plus 4- and
// 6-floor instances for ignored call bits and the fault latch.
module tb_elevator_scan_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 8-floor car
    logic [7:0] cu8 = '0, cd8 = '0, car8 = '0;
    logic [2:0] floor8 = '0;
    logic       at8 = 1'b1;
    logic       motor8, dir8, door8, fault8;
    logic [7:0] pu8, pd8, pc8;

    // 4-floor car
    logic [3:0] cu4 = '0, cd4 = '0, car4 = '0;
    logic [1:0] floor4 = '0;
    logic       at4 = 1'b1;
    logic       motor4, dir4, door4, fault4;
    logic [3:0] pu4, pd4, pc4;

    // 6-floor car
    logic [5:0] cu6 = '0, cd6 = '0, car6 = '0;
    logic [2:0] floor6 = '0;
    logic       at6 = 1'b1;
    logic       motor6, dir6, door6, fault6;
    logic [5:0] pu6, pd6, pc6;

    elevator_scan_controller #(.N_FLOORS(8), .DOOR_CYCLES(4)) u8 (
        .clk(clk), .rst(rst), .call_up(cu8), .call_dn(cd8), .car_req(car8),
        .floor_cur(floor8), .at_floor(at8), .motor(motor8), .direction(dir8),
        .door_open(door8), .pend_up(pu8), .pend_dn(pd8), .pend_car(pc8), .fault(fault8));

    elevator_scan_controller #(.N_FLOORS(4), .DOOR_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .call_up(cu4), .call_dn(cd4), .car_req(car4),
        .floor_cur(floor4), .at_floor(at4), .motor(motor4), .direction(dir4),
        .door_open(door4), .pend_up(pu4), .pend_dn(pd4), .pend_car(pc4), .fault(fault4));

    elevator_scan_controller #(.N_FLOORS(6), .DOOR_CYCLES(4)) u6 (
        .clk(clk), .rst(rst), .call_up(cu6), .call_dn(cd6), .car_req(car6),
        .floor_cur(floor6), .at_floor(at6), .motor(motor6), .direction(dir6),
        .door_open(door6), .pend_up(pu6), .pend_dn(pd6), .pend_car(pc6), .fault(fault6));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (motor8 !== 1'b0) begin errors++; $display("FAIL reset_motor: got %b want 0", motor8); end
        checks++; if (dir8 !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", dir8); end
        checks++; if (door8 !== 1'b0) begin errors++; $display("FAIL reset_door: got %b want 0", door8); end
        checks++; if ({pu8, pd8, pc8} !== 24'h0) begin errors++; $display("FAIL reset_pend: got %h want 0", {pu8, pd8, pc8}); end
        checks++; if ({fault8, fault4, fault6} !== 3'b000) begin errors++; $display("FAIL reset_fault: got %b want 000", {fault8, fault4, fault6}); end
    endtask

    task automatic test_car_request();
        floor8 = 3'd0; at8 = 1'b1;
        car8 = 8'h20; tick(); car8 = '0;
        checks++; if ({motor8, pc8[5]} !== 2'b01) begin errors++; $display("FAIL t1_latch: motor,pend_car5 got %b want 01", {motor8, pc8[5]}); end
        tick();
        checks++; if ({motor8, dir8} !== 2'b11) begin errors++; $display("FAIL t1_depart: motor,dir got %b want 11", {motor8, dir8}); end
        floor8 = 3'd5; tick();
        checks++; if ({motor8, door8, pc8[5]} !== 3'b010) begin errors++; $display("FAIL t1_stop: motor,door,pend_car5 got %b want 010", {motor8, door8, pc8[5]}); end
        repeat (3) tick();
        checks++; if (door8 !== 1'b1) begin errors++; $display("FAIL t1_dwell: door got %b want 1", door8); end
        tick();
        checks++; if (door8 !== 1'b0) begin errors++; $display("FAIL t1_close: door got %b want 0", door8); end
        tick();
        checks++; if ({motor8, door8} !== 2'b00) begin errors++; $display("FAIL t1_idle: motor,door got %b want 00", {motor8, door8}); end
    endtask

    task automatic test_scan_sweep();
        floor8 = 3'd1; at8 = 1'b1;
        car8 = 8'h40; tick(); car8 = '0; tick();
        checks++; if ({motor8, dir8} !== 2'b11) begin errors++; $display("FAIL t2_depart: motor,dir got %b want 11", {motor8, dir8}); end
        at8 = 1'b0; cu8 = 8'h08; cd8 = 8'h10; tick(); cu8 = '0; cd8 = '0;
        floor8 = 3'd2; at8 = 1'b1; tick();
        checks++; if (motor8 !== 1'b1) begin errors++; $display("FAIL t2_pass2: motor got %b want 1", motor8); end
        floor8 = 3'd3; tick();
        checks++; if ({motor8, door8, pu8[3], pd8[4]} !== 4'b0101) begin errors++; $display("FAIL t2_stop3: motor,door,pu3,pd4 got %b want 0101", {motor8, door8, pu8[3], pd8[4]}); end
        repeat (4) tick(); tick();
        checks++; if ({motor8, dir8} !== 2'b11) begin errors++; $display("FAIL t2_resume: motor,dir got %b want 11", {motor8, dir8}); end
        floor8 = 3'd4; tick();
        checks++; if ({motor8, door8, pd8[4]} !== 3'b101) begin errors++; $display("FAIL t2_pass4: motor,door,pd4 got %b want 101", {motor8, door8, pd8[4]}); end
        floor8 = 3'd5; tick();
        floor8 = 3'd6; tick();
        checks++; if ({motor8, door8, pc8[6]} !== 3'b010) begin errors++; $display("FAIL t2_stop6: motor,door,pc6 got %b want 010", {motor8, door8, pc8[6]}); end
        repeat (4) tick(); tick();
        checks++; if ({motor8, dir8} !== 2'b10) begin errors++; $display("FAIL t2_reverse: motor,dir got %b want 10", {motor8, dir8}); end
        floor8 = 3'd5; tick();
        floor8 = 3'd4; tick();
        checks++; if ({motor8, door8, pd8[4]} !== 3'b010) begin errors++; $display("FAIL t2_stop4: motor,door,pd4 got %b want 010", {motor8, door8, pd8[4]}); end
        repeat (4) tick();
    endtask

    task automatic test_door_reload();
        floor8 = 3'd2; at8 = 1'b1;
        cu8 = 8'h04; tick(); cu8 = '0;
        checks++; if ({pu8[2], door8} !== 2'b10) begin errors++; $display("FAIL t3_latch: pu2,door got %b want 10", {pu8[2], door8}); end
        tick();
        checks++; if ({door8, motor8, pu8[2]} !== 3'b100) begin errors++; $display("FAIL t3_open: door,motor,pu2 got %b want 100", {door8, motor8, pu8[2]}); end
        tick();
        cu8 = 8'h04; tick(); cu8 = '0;
        checks++; if ({door8, pu8[2]} !== 2'b10) begin errors++; $display("FAIL t3_press_in_door: door,pu2 got %b want 10", {door8, pu8[2]}); end
        repeat (3) tick();
        checks++; if (door8 !== 1'b1) begin errors++; $display("FAIL t3_reload_hold: door got %b want 1", door8); end
        tick();
        checks++; if ({door8, motor8} !== 2'b00) begin errors++; $display("FAIL t3_reload_close: door,motor got %b want 00", {door8, motor8}); end
    endtask

    task automatic test_ignored_bits();
        floor4 = 2'd0; at4 = 1'b1;
        cu4 = 4'b1000; cd4 = 4'b0001; tick(); cu4 = '0; cd4 = '0; tick();
        checks++; if ({pu4[3], pd4[0], motor4, door4} !== 4'b0000) begin errors++; $display("FAIL t4_ignored: pu3,pd0,motor,door got %b want 0000", {pu4[3], pd4[0], motor4, door4}); end
    endtask

    task automatic test_async_reset();
        floor8 = 3'd4; at8 = 1'b1;
        car8 = 8'h02; tick(); car8 = '0; tick();
        checks++; if ({motor8, dir8} !== 2'b10) begin errors++; $display("FAIL t5_moving_dn: motor,dir got %b want 10", {motor8, dir8}); end
        floor8 = 3'd3; at8 = 1'b0;
        cu8 = 8'h40; tick(); cu8 = '0;
        #3 rst = 1'b0;
        #1;
        checks++; if ({motor8, door8, dir8} !== 3'b001) begin errors++; $display("FAIL t5_async_out: motor,door,dir got %b want 001", {motor8, door8, dir8}); end
        checks++; if ({pu8, pd8, pc8} !== 24'h0) begin errors++; $display("FAIL t5_async_pend: got %h want 0", {pu8, pd8, pc8}); end
        #1 rst = 1'b1;
        at8 = 1'b1; tick(); tick();
        checks++; if (motor8 !== 1'b0) begin errors++; $display("FAIL t5_lost: motor got %b want 0", motor8); end
    endtask

    task automatic test_fault();
        floor6 = 3'd0; at6 = 1'b1;
        car6 = 6'b010000; tick(); car6 = '0; tick();
        checks++; if (motor6 !== 1'b1) begin errors++; $display("FAIL t6_moving: motor got %b want 1", motor6); end
        floor6 = 3'd7; at6 = 1'b0; tick();
        checks++; if ({fault6, motor6, door6} !== 3'b100) begin errors++; $display("FAIL t6_fault: fault,motor,door got %b want 100", {fault6, motor6, door6}); end
        car6 = 6'b000100; tick(); car6 = '0;
        checks++; if (pc6[2] !== 1'b1) begin errors++; $display("FAIL t6_latch: pc2 got %b want 1", pc6[2]); end
        floor6 = 3'd2; at6 = 1'b1; tick(); tick();
        checks++; if ({fault6, motor6, door6} !== 3'b100) begin errors++; $display("FAIL t6_sticky: fault,motor,door got %b want 100", {fault6, motor6, door6}); end
        #3 rst = 1'b0;
        #1;
        checks++; if (fault6 !== 1'b0) begin errors++; $display("FAIL t6_clear: fault got %b want 0", fault6); end
        #1 rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        tick();
        test_reset();
        test_car_request();
        test_scan_sweep();
        test_door_reload();
        test_ignored_bits();
        test_async_reset();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
